allocator_rr: RTL and testbench

ALLOCATOR_RR -- requirements
Module: allocator_rr

---
 rtl/alloc_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/allocator_rr.sv | 93 +++++++++
 tb/tb_allocator_rr.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/alloc_pkg.sv
// Shared phit type encoding and allocator state for the output-port allocator.
package alloc_pkg;

    localparam int TYPE_W = 2;

    typedef enum logic [TYPE_W-1:0] {
        PH_IDLE    = 2'd0,
        PH_TAIL    = 2'd1,
        PH_PAYLOAD = 2'd2,
        PH_HEAD    = 2'd3
    } phit_type_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } alloc_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or above ptr_i, wrapping.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] grant_idx_o
);

    always_comb begin
        int   j;
        logic found;
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        j           = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr_i) + i;
            if (j >= N) j = j - N;
            if (!found && req_i[j]) begin
                found       = 1'b1;
                grant_o[j]  = 1'b1;
                grant_idx_o = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/allocator_rr.sv
// Output-port allocator: same-cycle grant to HEAD phits, held through PAYLOAD, released on TAIL.
// Define ALLOCATOR_RR_FIXED_PRIO_EN to pin the arbiter pointer at 0 (input 0 always wins).
module allocator_rr #(
    parameter int N_PORTS = 4,
    parameter int PORT_W  = $clog2(N_PORTS)
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [PORT_W-1:0]                i_this_port,
    input  logic [N_PORTS-1:0][1:0]          i_type,
    input  logic [N_PORTS-1:0][PORT_W-1:0]   i_dest,
    output logic [N_PORTS-1:0]               o_select,
    output logic                             o_shift,
    output logic                             o_busy,
    output logic [PORT_W-1:0]                o_owner
);
    import alloc_pkg::*;

    localparam int IDX_W = $clog2(N_PORTS);

    alloc_state_t     state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic [N_PORTS-1:0] req;
    logic [N_PORTS-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    phit_type_t         owner_type;
    logic               hold;

    always_comb begin
        req = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            req[k] = (phit_type_t'(i_type[k]) == PH_HEAD) && (i_dest[k] == i_this_port);
        end
    end

    rr_arbiter #(.N(N_PORTS), .IDX_W(IDX_W)) u_arb (
        .req_i       (req),
        .ptr_i       (ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    assign owner_type = phit_type_t'(i_type[owner_q]);
    // An owner sending IDLE or HEAD has finished; the port frees up this very cycle.
    assign hold = (state_q == ST_BUSY) &&
                  ((owner_type == PH_PAYLOAD) || (owner_type == PH_TAIL));

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        o_select = '0;
        o_shift  = 1'b0;
        if (hold) begin
            o_select[owner_q] = 1'b1;
            if (owner_type == PH_TAIL) begin
                state_d = ST_IDLE;
                owner_d = '0;
            end
        end else if (|req) begin
            o_select = grant;
            o_shift  = 1'b1;
            state_d  = ST_BUSY;
            owner_d  = grant_idx;
`ifdef ALLOCATOR_RR_FIXED_PRIO_EN
            ptr_d    = '0;
`else
            ptr_d    = (grant_idx == IDX_W'(N_PORTS - 1)) ? '0 : grant_idx + IDX_W'(1);
`endif
        end else begin
            state_d = ST_IDLE;
            owner_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    assign o_busy  = (state_q == ST_BUSY);
    assign o_owner = PORT_W'(owner_q);

endmodule

// File: tb/tb_allocator_rr.sv
// Directed bench for allocator_rr with N_PORTS=4, this port = 2.
module tb_allocator_rr;

    localparam int N  = 4;
    localparam int PW = 2;

    localparam logic [1:0] T_IDLE = 2'd0;
    localparam logic [1:0] T_TAIL = 2'd1;
    localparam logic [1:0] T_PAY  = 2'd2;
    localparam logic [1:0] T_HEAD = 2'd3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [PW-1:0]         this_port;
    logic [N-1:0][1:0]     typ;
    logic [N-1:0][PW-1:0]  dest;
    logic [N-1:0]          sel;
    logic                  shift;
    logic                  busy;
    logic [PW-1:0]         owner;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    allocator_rr #(.N_PORTS(N), .PORT_W(PW)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_this_port (this_port),
        .i_type      (typ),
        .i_dest      (dest),
        .o_select    (sel),
        .o_shift     (shift),
        .o_busy      (busy),
        .o_owner     (owner)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and return the inputs to all-idle, 1 time unit after the edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        typ  = '0;
        dest = '0;
    endtask

    task automatic put(input int k, input logic [1:0] t, input logic [PW-1:0] d);
        typ[k]  = t;
        dest[k] = d;
    endtask

    task automatic expect_out(input string tag, input logic [N-1:0] s, input logic sh,
                              input logic b, input logic [PW-1:0] o);
        #1;
        check({tag, ".sel"},   32'(sel),   32'(s));
        check({tag, ".shift"}, 32'(shift), 32'(sh));
        check({tag, ".busy"},  32'(busy),  32'(b));
        check({tag, ".owner"}, 32'(owner), 32'(o));
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        typ  = '0;
        dest = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int exp_grant [5];

    initial begin
        this_port = 2'd2;
        do_reset();
        expect_out("reset", 4'b0000, 1'b0, 1'b0, 2'd0);

        // Single packet from input 0; a HEAD for another port is ignored afterwards.
        next_cycle(); put(0, T_HEAD, 2'd2);              expect_out("pkt.head", 4'b0001, 1'b1, 1'b0, 2'd0);
        next_cycle(); put(0, T_PAY,  2'd0);              expect_out("pkt.pay1", 4'b0001, 1'b0, 1'b1, 2'd0);
        next_cycle(); put(0, T_PAY,  2'd0);              expect_out("pkt.pay2", 4'b0001, 1'b0, 1'b1, 2'd0);
        next_cycle(); put(0, T_TAIL, 2'd0);              expect_out("pkt.tail", 4'b0001, 1'b0, 1'b1, 2'd0);
        next_cycle(); put(1, T_HEAD, 2'd3);              expect_out("pkt.after", 4'b0000, 1'b0, 1'b0, 2'd0);

        // Round-robin rotation with all four inputs contending; reset must clear the pointer.
        do_reset();
`ifdef ALLOCATOR_RR_FIXED_PRIO_EN
        exp_grant = '{0, 0, 0, 0, 0};
`else
        exp_grant = '{0, 1, 2, 3, 0};
`endif
        for (int r = 0; r < 5; r++) begin
            next_cycle();
            for (int k = 0; k < N; k++) put(k, T_HEAD, 2'd2);
            expect_out($sformatf("rr%0d.head", r), 4'(1 << exp_grant[r]), 1'b1, 1'b0, 2'd0);
            next_cycle();
            put(exp_grant[r], T_TAIL, 2'd0);
            expect_out($sformatf("rr%0d.tail", r), 4'(1 << exp_grant[r]), 1'b0, 1'b1,
                       PW'(exp_grant[r]));
        end

        // Contender waits for tail plus one; then an IDLE owner releases in the same cycle.
        do_reset();
        next_cycle(); put(1, T_HEAD, 2'd2);                              expect_out("wait.g1", 4'b0010, 1'b1, 1'b0, 2'd0);
        next_cycle(); put(1, T_PAY, 2'd0); put(3, T_HEAD, 2'd2);         expect_out("wait.pay", 4'b0010, 1'b0, 1'b1, 2'd1);
        next_cycle(); put(1, T_TAIL, 2'd0); put(3, T_HEAD, 2'd2);        expect_out("wait.tail", 4'b0010, 1'b0, 1'b1, 2'd1);
        next_cycle(); put(3, T_HEAD, 2'd2);                              expect_out("wait.g3", 4'b1000, 1'b1, 1'b0, 2'd0);
        next_cycle(); put(3, T_TAIL, 2'd0);                              expect_out("wait.t3", 4'b1000, 1'b0, 1'b1, 2'd3);
        next_cycle(); put(1, T_HEAD, 2'd2);                              expect_out("rel.g1", 4'b0010, 1'b1, 1'b0, 2'd0);
        next_cycle(); put(1, T_PAY, 2'd0); put(3, T_HEAD, 2'd2);         expect_out("rel.pay", 4'b0010, 1'b0, 1'b1, 2'd1);
        next_cycle(); put(1, T_IDLE, 2'd0); put(3, T_HEAD, 2'd2);        expect_out("rel.g3", 4'b1000, 1'b1, 1'b1, 2'd1);
        next_cycle(); put(3, T_TAIL, 2'd0);                              expect_out("rel.t3", 4'b1000, 1'b0, 1'b1, 2'd3);

        // Owner 1 re-heads while input 0 requests; pointer at 2 wraps around to input 0.
        do_reset();
        next_cycle(); put(1, T_HEAD, 2'd2);                              expect_out("rehead.g1", 4'b0010, 1'b1, 1'b0, 2'd0);
        next_cycle(); put(1, T_PAY, 2'd0);                               expect_out("rehead.pay", 4'b0010, 1'b0, 1'b1, 2'd1);
        next_cycle(); put(1, T_HEAD, 2'd2); put(0, T_HEAD, 2'd2);        expect_out("rehead.g0", 4'b0001, 1'b1, 1'b1, 2'd1);
        next_cycle(); put(0, T_PAY, 2'd0);                               expect_out("rehead.own", 4'b0001, 1'b0, 1'b1, 2'd0);

        // Reset in the middle of a packet drops the hold.
        do_reset();
        next_cycle(); put(0, T_HEAD, 2'd2);                              expect_out("mrst.g0", 4'b0001, 1'b1, 1'b0, 2'd0);
        next_cycle(); put(0, T_PAY, 2'd0);                               expect_out("mrst.pay", 4'b0001, 1'b0, 1'b1, 2'd0);
        next_cycle(); put(0, T_PAY, 2'd0); rst = 1'b1;
        next_cycle(); rst = 1'b0; put(0, T_PAY, 2'd0);                   expect_out("mrst.drop", 4'b0000, 1'b0, 1'b0, 2'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
